// File: rtl/audio_session_ctrl_if.sv
// Command and status bundle between the button logic, the session sequencer
// and the record/playback datapath plus progress display.
interface audio_session_ctrl_if;
    logic       btn_rec;
    logic       btn_play;
    logic       btn_stop;
    logic [1:0] menu;
    logic [5:0] progress;
    logic [5:0] rec_len;
    logic       tick;
    logic       done;

    modport master (
        output btn_rec, btn_play, btn_stop,
        input  menu, progress, rec_len, tick, done
    );

    modport slave (
        input  btn_rec, btn_play, btn_stop,
        output menu, progress, rec_len, tick, done
    );
endinterface

// File: rtl/audio_session_ctrl.sv
// Record/playback session sequencer: turns command pulses into the menu mode
// code, runs the 1 s timebase and tracks progress and the stored recording length.
module audio_session_ctrl #(
    parameter int TICK_DIV = 50000000,
    parameter int MAX_SEC  = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    audio_session_ctrl_if.slave  bus
);
    localparam int              PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [5:0]      MAX_LEN    = 6'(MAX_SEC);

    // Encodings equal the menu codes so menu is the state register itself.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        PLAY   = 2'b01,
        RECORD = 2'b10,
        PAUSE  = 2'b11
    } state_t;

    state_t          state_reg;
    logic [PW-1:0]   presc_reg;
    logic [5:0]      progress_reg;
    logic [5:0]      rec_len_reg;
    logic            done_reg;

    logic            running;
    logic            tick_now;
    logic [PW-1:0]   presc_next;
    logic [5:0]      progress_next;

    assign running       = (state_reg == RECORD) || (state_reg == PLAY);
    assign tick_now      = running && (presc_reg == PRESC_LAST);
    assign presc_next    = tick_now ? '0 : presc_reg + PW'(1);
    // Saturating increment; the session limits keep this from ever mattering.
    assign progress_next = (progress_reg == 6'd63) ? progress_reg : progress_reg + 6'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            presc_reg    <= '0;
            progress_reg <= '0;
            rec_len_reg  <= '0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    presc_reg <= '0;
                    if (!bus.btn_stop) begin
                        if (bus.btn_rec) begin
                            state_reg    <= RECORD;
                            progress_reg <= '0;
                        end else if (bus.btn_play && (rec_len_reg != 6'd0)) begin
                            state_reg    <= PLAY;
                            progress_reg <= '0;
                        end
                    end
                end
                RECORD: begin
                    if (bus.btn_stop) begin
                        // Stop beats a coincident tick: only completed seconds are kept.
                        state_reg   <= IDLE;
                        presc_reg   <= '0;
                        rec_len_reg <= progress_reg;
                        done_reg    <= 1'b1;
                    end else begin
                        presc_reg <= presc_next;
                        if (tick_now) begin
                            progress_reg <= progress_next;
                            if (progress_next == MAX_LEN) begin
                                state_reg   <= IDLE;
                                presc_reg   <= '0;
                                rec_len_reg <= MAX_LEN;
                                done_reg    <= 1'b1;
                            end
                        end
                    end
                end
                PLAY: begin
                    if (bus.btn_stop) begin
                        state_reg <= IDLE;
                        presc_reg <= '0;
                        done_reg  <= 1'b1;
                    end else begin
                        presc_reg <= presc_next;
                        if (tick_now) begin
                            progress_reg <= progress_next;
                        end
                        if (tick_now && (progress_next >= rec_len_reg)) begin
                            state_reg <= IDLE;
                            presc_reg <= '0;
                            done_reg  <= 1'b1;
                        end else if (bus.btn_play) begin
                            state_reg <= PAUSE;
                        end
                    end
                end
                PAUSE: begin
                    // Prescaler and progress hold so resume continues mid-second.
                    if (bus.btn_stop) begin
                        state_reg <= IDLE;
                        presc_reg <= '0;
                        done_reg  <= 1'b1;
                    end else if (bus.btn_play) begin
                        state_reg <= PLAY;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.menu     = state_reg;
    assign bus.progress = progress_reg;
    assign bus.rec_len  = rec_len_reg;
    assign bus.tick     = tick_now;
    assign bus.done     = done_reg;
endmodule

// File: tb/tb_audio_session_ctrl.sv
// Directed vector bench for audio_session_ctrl with TICK_DIV=4, MAX_SEC=5:
// each row is one clock edge of commands plus the outputs expected after it.
module tb_audio_session_ctrl;
    localparam int TDIV = 4;
    localparam int MSEC = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    audio_session_ctrl_if bus ();

    audio_session_ctrl #(.TICK_DIV(TDIV), .MAX_SEC(MSEC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic       rst, rec, play, stop;
        logic [1:0] menu;
        logic [5:0] prog;
        logic [5:0] len;
        logic       tick;
        logic       done;
    } vec_t;

    vec_t vecs[$];
    int   applied = 0;
    int   miscompares = 0;

    function automatic void push(logic r, logic rc, logic pl, logic st,
                                 logic [1:0] m, int p, int l, logic t, logic d);
        vec_t v;
        v.rst = r; v.rec = rc; v.play = pl; v.stop = st;
        v.menu = m; v.prog = 6'(p); v.len = 6'(l); v.tick = t; v.done = d;
        vecs.push_back(v);
    endfunction

    // Idle-input rows k = from..to cycles into a running session.
    function automatic void seg(int from, int to, logic [1:0] m, int l);
        for (int k = from; k <= to; k++)
            push(1'b0, 1'b0, 1'b0, 1'b0, m, k / TDIV, l, 1'((k % TDIV) == TDIV - 1), 1'b0);
    endfunction

    task automatic apply(input logic r, input logic rc, input logic pl, input logic st);
        @(negedge clk);
        rst = r; bus.btn_rec = rc; bus.btn_play = pl; bus.btn_stop = st;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [1:0] m, input logic [5:0] p,
                         input logic [5:0] l, input logic t, input logic d);
        applied++;
        if (bus.menu !== m || bus.progress !== p || bus.rec_len !== l ||
            bus.tick !== t || bus.done !== d) begin
            miscompares++;
            $display("FAIL %s: got menu=%b prog=%0d len=%0d tick=%b done=%b, want menu=%b prog=%0d len=%0d tick=%b done=%b",
                     name, bus.menu, bus.progress, bus.rec_len, bus.tick, bus.done, m, p, l, t, d);
        end
    endtask

    initial begin
        int found;
        bus.btn_rec = 1'b0; bus.btn_play = 1'b0; bus.btn_stop = 1'b0;

        // Reset, play without a recording, stop in idle, reset beating rec.
        push(1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        push(0, 0, 1, 0, 2'b00, 0, 0, 0, 0);
        push(0, 0, 0, 1, 2'b00, 0, 0, 0, 0);
        push(1, 1, 0, 0, 2'b00, 0, 0, 0, 0);
        // Record to the MAX_SEC limit.
        push(0, 1, 0, 0, 2'b10, 0, 0, 0, 0);
        seg(1, 19, 2'b10, 0);
        push(0, 0, 0, 0, 2'b00, 5, 5, 0, 1);
        push(0, 0, 0, 0, 2'b00, 5, 5, 0, 0);
        // Record stopped after 10 cycles; rec/play mid-record ignored.
        push(0, 1, 0, 0, 2'b10, 0, 5, 0, 0);
        seg(1, 4, 2'b10, 5);
        push(0, 1, 1, 0, 2'b10, 1, 5, 0, 0);
        seg(6, 9, 2'b10, 5);
        push(0, 0, 0, 1, 2'b00, 2, 2, 0, 1);
        // Playback runs to the recorded length on its own.
        push(0, 0, 1, 0, 2'b01, 0, 2, 0, 0);
        seg(1, 7, 2'b01, 2);
        push(0, 0, 0, 0, 2'b00, 2, 2, 0, 1);
        push(0, 0, 0, 0, 2'b00, 2, 2, 0, 0);
        // Pause two cycles after a tick, hold, resume mid-second.
        push(0, 0, 1, 0, 2'b01, 0, 2, 0, 0);
        seg(1, 5, 2'b01, 2);
        push(0, 0, 1, 0, 2'b11, 1, 2, 0, 0);
        for (int i = 0; i < 50; i++) push(0, 0, 0, 0, 2'b11, 1, 2, 0, 0);
        push(0, 0, 1, 0, 2'b01, 1, 2, 0, 0);
        push(0, 0, 0, 0, 2'b01, 1, 2, 1, 0);
        push(0, 0, 0, 0, 2'b00, 2, 2, 0, 1);
        // Stop coincident with a record tick at progress 3.
        push(0, 1, 0, 0, 2'b10, 0, 2, 0, 0);
        seg(1, 15, 2'b10, 2);
        push(0, 0, 0, 1, 2'b00, 3, 3, 0, 1);
        // rec + play together in idle selects record.
        push(0, 1, 1, 0, 2'b10, 0, 3, 0, 0);
        seg(1, 8, 2'b10, 3);
        push(0, 0, 0, 1, 2'b00, 2, 2, 0, 1);
        // Play pressed in a tick cycle: tick counts, pause with prescaler at 0.
        push(0, 0, 1, 0, 2'b01, 0, 2, 0, 0);
        seg(1, 3, 2'b01, 2);
        push(0, 0, 1, 0, 2'b11, 1, 2, 0, 0);
        push(0, 0, 1, 0, 2'b01, 1, 2, 0, 0);
        push(0, 0, 0, 0, 2'b01, 1, 2, 0, 0);
        // Reset mid-play clears everything, later play is ignored.
        push(1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        push(0, 0, 1, 0, 2'b00, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].rec, vecs[i].play, vecs[i].stop);
            check($sformatf("vec%0d", i), vecs[i].menu, vecs[i].prog, vecs[i].len,
                  vecs[i].tick, vecs[i].done);
        end

        // Hand sequence: full record session timed by a bounded wait on done.
        apply(1'b0, 1'b1, 1'b0, 1'b0);
        found = 0;
        for (int c = 1; c <= 30 && found == 0; c++) begin
            apply(1'b0, 1'b0, 1'b0, 1'b0);
            if (bus.done === 1'b1) found = c;
        end
        applied++;
        if (found != TDIV * MSEC) begin
            miscompares++;
            $display("FAIL done_latency: got %0d cycles, want %0d", found, TDIV * MSEC);
        end
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        check("done_single", 2'b00, 6'd5, 6'd5, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule

// File: doc/audio_session_ctrl.md
# audio_session_ctrl

Sequencer for the record/playback session of the audio path. Turns single-cycle user command pulses (record, play/pause, stop) into the `menu` mode code that drives the audio datapath and progress display. Owns the 1-second timebase, counts elapsed seconds as a progress index, and remembers the length of the last recording so playback ends on its own. It sits between the debounced button logic and the record/playback datapath and display blocks.

## Interface
- `TICK_DIV`, default 50000000: clk cycles per progress tick (1 s at 50 MHz); must be ≥ 2.
- `MAX_SEC`, default 20: maximum recording length in ticks; must be 1..63.
- `clk`  in  1: system clock, single clock domain.
- `rst`  in  1: reset, synchronous and active-high.
- `btn_rec`  in  1: start-record command, one-cycle pulse.
- `btn_play`  in  1: play / pause / resume command, one-cycle pulse.
- `btn_stop`  in  1: stop command, one-cycle pulse.
- `menu`  out  2: mode code. 00 = idle, 01 = play, 10 = record, 11 = paused.
- `progress`  out  6: seconds elapsed in the current or last session.
- `rec_len`  out  6: length of the stored recording in seconds; 0 means no recording.
- `tick`  out  1: one-cycle pulse at each second boundary while in play or record.
- `done`  out  1: one-cycle pulse when a session ends, by stop or by reaching its limit.

## Operation
- States: IDLE, RECORD, PLAY, PAUSE. `menu` is a registered encoding of the state.
- Command priority when several commands arrive in the same cycle: `btn_stop` > `btn_rec` > `btn_play`. Commands not listed for the current state are ignored.
- **IDLE**
  - `btn_rec` → RECORD. Clears `progress` and the prescaler to 0.
  - `btn_play` with `rec_len` ≠ 0 → PLAY. Clears `progress` and the prescaler.
  - `btn_play` with `rec_len` = 0 → ignored.
  - `btn_stop` → no effect, and no `done` pulse.
- **RECORD**
  - Each `tick` increments `progress`.
  - The tick that takes `progress` to `MAX_SEC` also sets `rec_len` = `MAX_SEC`, moves to IDLE, and pulses `done`.
  - `btn_stop` sets `rec_len` to the current `progress` (completed seconds only), moves to IDLE, and pulses `done`.
  - `btn_play` and `btn_rec` are ignored.
- **PLAY**
  - Each `tick` increments `progress`.
  - The tick that takes `progress` to `rec_len` moves to IDLE and pulses `done`.
  - `btn_play` → PAUSE.
  - `btn_stop` → IDLE and pulses `done`.
  - `btn_rec` is ignored.
- **PAUSE**
  - Prescaler and `progress` hold their values.
  - `btn_play` → PLAY and resumes the prescaler from its held count; it is not cleared.
  - `btn_stop` → IDLE and pulses `done`.
  - `btn_rec` is ignored.
- `progress` holds its final value in IDLE until the next session starts.
- `rec_len` changes only when a record session ends, or on reset.
- Prescaler: ceil(log2(`TICK_DIV`))-bit up-counter.
  - Runs only in RECORD and PLAY.
  - Wraps from `TICK_DIV`-1 to 0; `tick` is asserted in the wrap cycle.
  - In IDLE it is held at 0.
- `progress` saturates at 63 and never wraps; this is defensive only, since the limits above make it unreachable.

## Timing
- Reset values: `menu` = 00, `progress` = 0, `rec_len` = 0, `tick` = 0, `done` = 0, prescaler = 0, state IDLE. `rst` overrides every command in the same cycle.
- Reset mid-session returns everything to the reset values, including `rec_len` = 0.
- A command sampled at edge N is reflected in `menu` after edge N.
- The first `tick` of a fresh session is asserted `TICK_DIV` cycles after the command edge. The `progress` increment is visible on the edge that ends the tick cycle.
- `tick` is combinational from the prescaler compare qualified by state, or registered one cycle earlier. Either way it must be high for exactly one cycle, aligned with the `progress` update edge.
- The session-ending tick and `done` occur on the same edge; `menu` = 00 from that edge on.
- Stop and tick in the same cycle: stop wins, and `progress` is not incremented. In RECORD, `rec_len` takes the pre-increment value.
- `btn_play` and tick in the same PLAY cycle: the tick counts (`progress` increments), and the state becomes PAUSE with the prescaler held at 0.
- `done` is never asserted in two consecutive cycles.

## Test plan
- Reset, then `btn_play` → `menu` stays 00 and `progress` stays 0, because `rec_len` = 0. Apply `rst` with `btn_rec` in the same cycle → `menu` = 00.
- With `TICK_DIV`=4 and `MAX_SEC`=5: `btn_rec` → `menu` = 10; ticks every 4 cycles; after 20 cycles `progress` = 5, `rec_len` = 5, `done` for 1 cycle, `menu` = 00.
- With `TICK_DIV`=4: `btn_rec`, then `btn_stop` 10 cycles later → `rec_len` = 2, `progress` = 2, `done` pulse. Then `btn_play` → `menu` = 01; `progress` steps 0→1→2; `done` 8 cycles after the play edge.
- During PLAY: `btn_play` 2 cycles after a tick → `menu` = 11 and the counters freeze. Hold for 50 cycles, then `btn_play` → the next tick arrives 2 cycles later.
- `btn_stop` coincident with a record tick at `progress` = 3 → `rec_len` = 3, not 4. `btn_rec` together with `btn_play` in IDLE → `menu` = 10.
- `rst` mid-PLAY → all outputs 0 on the next edge. `btn_play` afterwards is ignored.
